// File: rtl/sbox_lut_loader_if.sv
// Register-bus types and the master/slave interface between the S-box loader and the LUT responder.
// Request is driven by the loader; response (ready/error/rdata) comes back from the substitution layer.
package sbox_lut_loader_pkg;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [31:0]       wdata;
        logic [3:0]        wstrb;
        logic              valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

interface sbox_lut_loader_if;
    import sbox_lut_loader_pkg::*;

    reg_req_t req;
    reg_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);
endinterface

// File: rtl/sbox_lut_loader.sv
// Programs the 32-entry 5-bit Ascon S-box LUT over the register bus; one beat per cycle when ready is high.
// Optional read-back check after the write pass is compiled in with SBOX_LUT_LOADER_VERIFY_EN.
module sbox_lut_loader
    import sbox_lut_loader_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              NUM_ENTRIES = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic                use_custom_i,
    input  logic [159:0]        custom_table_i,
    sbox_lut_loader_if.master   sbox_reg,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [4:0]          err_idx_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
`ifdef SBOX_LUT_LOADER_VERIFY_EN
    localparam logic [1:0] S_READ  = 2'd2;
`endif
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0] LAST_IDX = 5'(NUM_ENTRIES - 1);

    // Entry 31 in the top bits down to entry 0 in bits [4:0].
    localparam logic [159:0] ASCON_SBOX = {
        5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
        5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
        5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
        5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
    };

    logic [1:0]   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [159:0] shadow_q, shadow_d;
    logic         err_q, err_d;
    logic [4:0]   err_idx_q, err_idx_d;

    logic [4:0]        entry;
    logic              in_write;
    logic              in_read;
    logic              hs;
    logic [ADDR_W-1:0] addr;

    assign entry    = shadow_q[5*cnt_q +: 5];
    assign in_write = (state_q == S_WRITE);
`ifdef SBOX_LUT_LOADER_VERIFY_EN
    assign in_read  = (state_q == S_READ);
`else
    assign in_read  = 1'b0;
`endif
    assign hs       = (in_write || in_read) && sbox_reg.rsp.ready;
    assign addr     = BASE_ADDR + ADDR_W'({cnt_q, 2'b00});

    // Request is a pure decode of registered state, so it holds steady across wait states.
    always_comb begin
        sbox_reg.req = '0;
        if (in_write || in_read) begin
            sbox_reg.req.valid = 1'b1;
            sbox_reg.req.addr  = addr;
        end
        if (in_write) begin
            sbox_reg.req.write = 1'b1;
            sbox_reg.req.wdata = {27'b0, entry};
            sbox_reg.req.wstrb = 4'hF;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    shadow_d  = use_custom_i ? custom_table_i : ASCON_SBOX;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    cnt_d     = '0;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (hs) begin
                    if (sbox_reg.rsp.error) begin
                        err_d     = 1'b1;
                        err_idx_d = cnt_q;
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                    end else if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
`ifdef SBOX_LUT_LOADER_VERIFY_EN
                        state_d = S_READ;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
`ifdef SBOX_LUT_LOADER_VERIFY_EN
            S_READ: begin
                if (hs) begin
                    if (sbox_reg.rsp.error || (sbox_reg.rsp.rdata[4:0] != entry)) begin
                        err_d     = 1'b1;
                        err_idx_d = cnt_q;
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                    end else if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign busy_o    = in_write || in_read;
    assign done_o    = (state_q == S_DONE);
    assign error_o   = err_q;
    assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_sbox_lut_loader.sv
// Directed bench for sbox_lut_loader: modelled LUT responder with stall, error and corruption injection.
module tb_sbox_lut_loader;
    import sbox_lut_loader_pkg::*;

`ifdef SBOX_LUT_LOADER_VERIFY_EN
    localparam int DONE_N = 65;
    localparam int RD_N   = 32;
`else
    localparam int DONE_N = 33;
    localparam int RD_N   = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         use_custom;
    logic [159:0] custom_table;
    logic         busy, done, error;
    logic [4:0]   err_idx;

    logic         rdy;
    int           err_at;
    logic         corrupt;
    logic [4:0]   lut [32];
    logic [4:0]   ridx;

    logic [31:0]  wr_addr [$];
    logic [31:0]  wr_dat  [$];
    int           rd_cnt;

    int checks   = 0;
    int failures = 0;

    logic [4:0] ascon_exp [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    always #5 clk = ~clk;

    sbox_lut_loader_if bus ();

    sbox_lut_loader dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .start_i        (start),
        .use_custom_i   (use_custom),
        .custom_table_i (custom_table),
        .sbox_reg       (bus),
        .busy_o         (busy),
        .done_o         (done),
        .error_o        (error),
        .err_idx_o      (err_idx)
    );

    assign ridx = bus.req.addr[6:2];

    always_comb begin
        bus.rsp       = '0;
        bus.rsp.ready = rdy;
        bus.rsp.error = (err_at >= 0) && bus.req.valid && (int'(ridx) == err_at);
        bus.rsp.rdata = {27'b0, lut[ridx] ^ ((corrupt && ridx == 5'd7) ? 5'h01 : 5'h00)};
    end

    // Responder memory and beat log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && bus.req.valid && bus.rsp.ready) begin
            if (bus.req.write) begin
                lut[ridx] = bus.req.wdata[4:0];
                wr_addr.push_back(bus.req.addr);
                wr_dat.push_back(bus.req.wdata);
            end else begin
                rd_cnt++;
            end
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_dat.delete();
        rd_cnt = 0;
    endtask

    task automatic pulse_start(input logic custom);
        @(posedge clk);
        #1 start = 1'b1; use_custom = custom;
        @(posedge clk);
        #1 start = 1'b0; use_custom = 1'b0;
    endtask

    task automatic run_seq(input int n0, input int max, output int n_done, output int n_end, output int busy_cnt);
        int n;
        n = n0; n_done = 0; n_end = 0; busy_cnt = 0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            n++;
            if (done && n_done == 0) n_done = n;
            if (busy) busy_cnt++;
            else begin
                n_end = n;
                break;
            end
        end
        checks++;
        if (n_end == 0) begin
            failures++;
            $display("FAIL run_timeout: busy still high after %0d cycles, required low", max);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; use_custom = 1'b0; custom_table = '0;
        rdy = 1'b1; err_at = -1; corrupt = 1'b0; rd_cnt = 0;
        for (int i = 0; i < 32; i++) lut[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks += 6;
        if (bus.req !== '0) begin failures++; $display("FAIL reset_req: got %h want 0", bus.req); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error); end
        if (err_idx !== 5'd0) begin failures++; $display("FAIL reset_err_idx: got %0d want 0", err_idx); end
        if (bus.req.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.req.valid); end
    endtask

    task automatic test_default_load();
        int n_done, n_end, busy_cnt;
        clear_log();
        pulse_start(1'b0);
        run_seq(0, 200, n_done, n_end, busy_cnt);
        checks += 5;
        if (n_done !== DONE_N) begin failures++; $display("FAIL default_done_cycle: got %0d want %0d", n_done, DONE_N); end
        if (busy_cnt !== DONE_N - 1) begin failures++; $display("FAIL default_busy_cycles: got %0d want %0d", busy_cnt, DONE_N - 1); end
        if (wr_dat.size() !== 32) begin failures++; $display("FAIL default_write_count: got %0d want 32", wr_dat.size()); end
        if (rd_cnt !== RD_N) begin failures++; $display("FAIL default_read_count: got %0d want %0d", rd_cnt, RD_N); end
        if (error !== 1'b0) begin failures++; $display("FAIL default_error: got %b want 0", error); end
        for (int i = 0; i < 32 && i < wr_dat.size(); i++) begin
            checks += 2;
            if (wr_addr[i] !== 32'(4 * i)) begin failures++; $display("FAIL default_addr[%0d]: got %h want %h", i, wr_addr[i], 4 * i); end
            if (wr_dat[i] !== {27'b0, ascon_exp[i]}) begin failures++; $display("FAIL default_wdata[%0d]: got %h want %h", i, wr_dat[i], ascon_exp[i]); end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL default_done_width: got %b want 0", done); end
    endtask

    task automatic test_back_pressure();
        int n, n_done, n_end, busy_cnt;
        clear_log();
        pulse_start(1'b0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (bus.req.valid && bus.req.addr == 32'h10) break;
        end
        @(posedge clk);
        #1 rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n++;
            checks += 3;
            if (bus.req.valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b want 1", s, bus.req.valid); end
            if (bus.req.addr !== 32'h14) begin failures++; $display("FAIL stall_addr[%0d]: got %h want 14", s, bus.req.addr); end
            if (bus.req.wdata !== 32'h15) begin failures++; $display("FAIL stall_wdata[%0d]: got %h want 15", s, bus.req.wdata); end
            @(posedge clk);
        end
        #1 rdy = 1'b1;
        run_seq(n, 200, n_done, n_end, busy_cnt);
        checks += 2;
        if (n_done !== DONE_N + 3) begin failures++; $display("FAIL stall_done_cycle: got %0d want %0d", n_done, DONE_N + 3); end
        if (wr_dat.size() !== 32) begin failures++; $display("FAIL stall_write_count: got %0d want 32", wr_dat.size()); end
    endtask

    task automatic test_write_error();
        int n_done, n_end, busy_cnt;
        clear_log();
        err_at = 10;
        pulse_start(1'b0);
        run_seq(0, 200, n_done, n_end, busy_cnt);
        checks += 5;
        if (n_done !== 0) begin failures++; $display("FAIL werr_done: got cycle %0d want none", n_done); end
        if (n_end !== 12) begin failures++; $display("FAIL werr_busy_drop: got cycle %0d want 12", n_end); end
        if (error !== 1'b1) begin failures++; $display("FAIL werr_error: got %b want 1", error); end
        if (err_idx !== 5'd10) begin failures++; $display("FAIL werr_idx: got %0d want 10", err_idx); end
        if (bus.req.valid !== 1'b0) begin failures++; $display("FAIL werr_valid: got %b want 0", bus.req.valid); end
        err_at = -1;
        repeat (3) @(negedge clk);
        checks += 2;
        if (error !== 1'b1) begin failures++; $display("FAIL werr_sticky: got %b want 1", error); end
        if (done !== 1'b0) begin failures++; $display("FAIL werr_late_done: got %b want 0", done); end
    endtask

    task automatic test_restart();
        int n_done, n_end, busy_cnt;
        pulse_start(1'b0);
        @(negedge clk);
        checks += 2;
        if (error !== 1'b0) begin failures++; $display("FAIL restart_error_clear: got %b want 0", error); end
        if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy: got %b want 1", busy); end
        run_seq(1, 200, n_done, n_end, busy_cnt);
        checks += 2;
        if (n_done !== DONE_N) begin failures++; $display("FAIL restart_done_cycle: got %0d want %0d", n_done, DONE_N); end
        if (error !== 1'b0) begin failures++; $display("FAIL restart_error: got %b want 0", error); end
    endtask

    task automatic test_custom_table();
        int n_done, n_end, busy_cnt;
        clear_log();
        for (int i = 0; i < 32; i++) custom_table[5*i +: 5] = 5'(31 - i);
        fork
            begin
                repeat (11) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join_none
        pulse_start(1'b1);
        run_seq(0, 200, n_done, n_end, busy_cnt);
        checks += 2;
        if (n_done !== DONE_N) begin failures++; $display("FAIL custom_done_cycle: got %0d want %0d", n_done, DONE_N); end
        if (wr_dat.size() !== 32) begin failures++; $display("FAIL custom_write_count: got %0d want 32", wr_dat.size()); end
        for (int i = 0; i < 32 && i < wr_dat.size(); i++) begin
            checks++;
            if (wr_dat[i] !== 32'(31 - i)) begin failures++; $display("FAIL custom_wdata[%0d]: got %h want %h", i, wr_dat[i], 31 - i); end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL custom_no_restart: got busy %b want 0", busy); end
    endtask

`ifdef SBOX_LUT_LOADER_VERIFY_EN
    task automatic test_verify_mismatch();
        int n_done, n_end, busy_cnt;
        clear_log();
        corrupt = 1'b1;
        pulse_start(1'b0);
        run_seq(0, 200, n_done, n_end, busy_cnt);
        checks += 4;
        if (n_done !== 0) begin failures++; $display("FAIL verify_done: got cycle %0d want none", n_done); end
        if (n_end !== 41) begin failures++; $display("FAIL verify_busy_drop: got cycle %0d want 41", n_end); end
        if (error !== 1'b1) begin failures++; $display("FAIL verify_error: got %b want 1", error); end
        if (err_idx !== 5'd7) begin failures++; $display("FAIL verify_idx: got %0d want 7", err_idx); end
        corrupt = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        bit seen;
        pulse_start(1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.req.valid && bus.req.addr == 32'h30) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rstmid_reach_entry12: got no entry-12 beat, want one"); end
        #1 rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.req.valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b want 0", bus.req.valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b want 0", done); end
        if (error !== 1'b0) begin failures++; $display("FAIL rstmid_error: got %b want 0", error); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle_after: got busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_default_load();
        test_back_pressure();
        test_write_error();
        test_restart();
        test_custom_table();
`ifdef SBOX_LUT_LOADER_VERIFY_EN
        test_verify_mismatch();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
